// File: rtl/npu_sched_seq.sv
// npu_sched_seq -- NPU schedule sequencer.
//
// Holds a program of control words {last, rpt, ctrl} and, on start, plays
// it back for a configurable number of iterations. Each word is held on the
// control outputs for rpt+1 cycles. Stall inserts bubbles, abort returns to
// IDLE. A one-cycle done pulse follows the final word.
//
// Optional feature: define NPU_SCHED_PERF_EN to build the active/stall
// cycle counters. When it is undefined those ports read as 0.
//
// Ports:
//   CLK, npu_rst                      clock, synchronous active-high reset
//   npu_sched_write_en / _din         append a word (IDLE only, not full)
//   npu_sched_start / _iter           start request and iteration count
//   npu_sched_stall / _abort          bubble insertion / run termination
//   npu_sched_busy / _done / _full    status (all registered)
//   npu_sched_*_en, *_sel*            registered control fields of the word
//   npu_sched_active_cycles           RUN cycles without stall
//   npu_sched_stall_cycles            RUN cycles with stall
//
// state | meaning
// IDLE  | program load allowed, waiting for start
// RUN   | playing words, outputs follow word[pc]
// DONE  | one cycle emitting the done pulse
module npu_sched_seq #(
   parameter int PE_SEL_W = 3,
   parameter int RPT_W    = 4,
   parameter int DEPTH    = 64,
   parameter int ADDR_W   = 6,
   parameter int ITER_W   = 8,
   localparam int CTRL_W  = 10 + 2*PE_SEL_W,
   localparam int WORD_W  = CTRL_W + RPT_W + 1
) (
   input  logic                CLK,
   input  logic                npu_rst,
   input  logic                npu_sched_write_en,
   input  logic [WORD_W-1:0]   npu_sched_din,
   input  logic                npu_sched_start,
   input  logic [ITER_W-1:0]   npu_sched_iter,
   input  logic                npu_sched_stall,
   input  logic                npu_sched_abort,
   output logic                npu_sched_busy,
   output logic                npu_sched_done,
   output logic                npu_sched_full,
   output logic                npu_sched_input_fifo_read_en,
   output logic                npu_sched_sigmoid_fifo_read_en,
   output logic                npu_sched_sigmoid_fifo_write_en,
   output logic                npu_sched_output_fifo_write_en,
   output logic [PE_SEL_W-1:0] npu_sched_pe_select_in,
   output logic                npu_sched_pe_write_en,
   output logic                npu_sched_acc_fifo_read_en,
   output logic                npu_sched_acc_fifo_write_en,
   output logic [PE_SEL_W-1:0] npu_sched_sigmoid_input_sel_pe,
   output logic                npu_sched_sigmoid_input_en,
   output logic [1:0]          npu_sched_sigmoid_function_sel,
   output logic [31:0]         npu_sched_active_cycles,
   output logic [31:0]         npu_sched_stall_cycles
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_t              state;
   logic [WORD_W-1:0]   mem [DEPTH];
   logic [ADDR_W:0]     count;
   logic [ADDR_W-1:0]   pc;
   logic [RPT_W-1:0]    rpt_cnt;
   logic [ITER_W-1:0]   iter_cnt;
   logic [CTRL_W-1:0]   ctrl_q;
   logic                busy_q, done_q, full_q;

   logic                wr_ok, start_ok, cur_last, at_end;
   logic [ADDR_W-1:0]   pc_inc;
   logic [ADDR_W:0]     last_idx;
   logic [CTRL_W-1:0]   cur_ctrl;
   logic [RPT_W-1:0]    nxt_rpt, first_rpt;

   assign wr_ok     = (state == S_IDLE) && npu_sched_write_en && !full_q;
   assign start_ok  = (state == S_IDLE) && npu_sched_start && !npu_sched_abort;
   assign pc_inc    = pc + ADDR_W'(1);
   assign last_idx  = count - ONE_C;
   assign cur_last  = mem[pc][WORD_W-1];
   assign cur_ctrl  = mem[pc][CTRL_W-1:0];
   assign nxt_rpt   = mem[pc_inc][CTRL_W +: RPT_W];
   assign first_rpt = mem[0][CTRL_W +: RPT_W];
   // The stored count bounds the program even when no word carries last.
   assign at_end    = cur_last || ({1'b0, pc} == last_idx);

   // Program storage has no reset; the write pointer alone defines contents.
   always_ff @(posedge CLK) begin
      if (!npu_rst && wr_ok)
         mem[count[ADDR_W-1:0]] <= npu_sched_din;
   end

   always_ff @(posedge CLK) begin
      if (npu_rst) begin
         state    <= S_IDLE;
         count    <= '0;
         pc       <= '0;
         rpt_cnt  <= '0;
         iter_cnt <= '0;
         ctrl_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         full_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (wr_ok) begin
            count  <= count + ONE_C;
            full_q <= ((count + ONE_C) == DEPTH_C);
         end
         if (npu_sched_abort) begin
            state  <= S_IDLE;
            ctrl_q <= '0;
            busy_q <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  ctrl_q <= '0;
                  busy_q <= 1'b0;
                  if (start_ok) begin
                     iter_cnt <= (npu_sched_iter == '0) ? ITER_W'(1) : npu_sched_iter;
                     pc       <= '0;
                     rpt_cnt  <= first_rpt;
                     state    <= (count != '0) ? S_RUN : S_DONE;
                  end
               end
               S_RUN: begin
                  if (npu_sched_stall) begin
                     ctrl_q <= '0;
                  end else begin
                     ctrl_q <= cur_ctrl;
                     busy_q <= 1'b1;
                     if (rpt_cnt != '0) begin
                        rpt_cnt <= rpt_cnt - RPT_W'(1);
                     end else if (!at_end) begin
                        pc      <= pc_inc;
                        rpt_cnt <= nxt_rpt;
                     end else if (iter_cnt > ITER_W'(1)) begin
                        // Wrap straight into word 0 so iterations run back to back.
                        iter_cnt <= iter_cnt - ITER_W'(1);
                        pc       <= '0;
                        rpt_cnt  <= first_rpt;
                     end else begin
                        state <= S_DONE;
                     end
                  end
               end
               S_DONE: begin
                  ctrl_q <= '0;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign npu_sched_busy                  = busy_q;
   assign npu_sched_done                  = done_q;
   assign npu_sched_full                  = full_q;
   assign npu_sched_input_fifo_read_en    = ctrl_q[0];
   assign npu_sched_sigmoid_fifo_read_en  = ctrl_q[1];
   assign npu_sched_sigmoid_fifo_write_en = ctrl_q[2];
   assign npu_sched_output_fifo_write_en  = ctrl_q[3];
   assign npu_sched_pe_select_in          = ctrl_q[PE_SEL_W+3:4];
   assign npu_sched_pe_write_en           = ctrl_q[PE_SEL_W+4];
   assign npu_sched_acc_fifo_read_en      = ctrl_q[PE_SEL_W+5];
   assign npu_sched_acc_fifo_write_en     = ctrl_q[PE_SEL_W+6];
   assign npu_sched_sigmoid_input_sel_pe  = ctrl_q[2*PE_SEL_W+6:PE_SEL_W+7];
   assign npu_sched_sigmoid_input_en      = ctrl_q[2*PE_SEL_W+7];
   assign npu_sched_sigmoid_function_sel  = ctrl_q[CTRL_W-1:CTRL_W-2];

`ifdef NPU_SCHED_PERF_EN
   logic [31:0] active_q, stall_q;

   always_ff @(posedge CLK) begin
      if (npu_rst || start_ok) begin
         active_q <= '0;
         stall_q  <= '0;
      end else if (state == S_RUN) begin
         if (npu_sched_stall) begin
            if (stall_q != '1) stall_q <= stall_q + 32'd1;
         end else begin
            if (active_q != '1) active_q <= active_q + 32'd1;
         end
      end
   end

   assign npu_sched_active_cycles = active_q;
   assign npu_sched_stall_cycles  = stall_q;
`else
   assign npu_sched_active_cycles = '0;
   assign npu_sched_stall_cycles  = '0;
`endif

endmodule

// File: tb/tb_npu_sched_seq.sv
// Testbench for npu_sched_seq: directed and randomized programs checked
// against a queue-based model that expands each program into its expected
// per-cycle control trace.
module tb_npu_sched_seq;
   localparam int PE_SEL_W = 3;
   localparam int RPT_W    = 4;
   localparam int DEPTH    = 64;
   localparam int ITER_W   = 8;
   localparam int CTRL_W   = 10 + 2*PE_SEL_W;
   localparam int WORD_W   = CTRL_W + RPT_W + 1;

   logic                CLK = 1'b0;
   logic                npu_rst = 1'b1;
   logic                write_en = 1'b0;
   logic [WORD_W-1:0]   din = '0;
   logic                start = 1'b0;
   logic [ITER_W-1:0]   iter = '0;
   logic                stall = 1'b0;
   logic                abort = 1'b0;
   logic                busy, done, full;
   logic                in_rd, sg_rd, sg_wr, out_wr, pe_we, acc_rd, acc_wr, sg_in_en;
   logic [PE_SEL_W-1:0] pe_sel, sg_in_sel;
   logic [1:0]          fn_sel;
   logic [31:0]         active_cyc, stall_cyc;
   logic [CTRL_W-1:0]   obs_ctrl;

   int vectors = 0;
   int miscompares = 0;
   logic [WORD_W-1:0] prog[$];
   logic [CTRL_W-1:0] exp_q[$];

   npu_sched_seq dut (
      .CLK(CLK), .npu_rst(npu_rst),
      .npu_sched_write_en(write_en), .npu_sched_din(din),
      .npu_sched_start(start), .npu_sched_iter(iter),
      .npu_sched_stall(stall), .npu_sched_abort(abort),
      .npu_sched_busy(busy), .npu_sched_done(done), .npu_sched_full(full),
      .npu_sched_input_fifo_read_en(in_rd),
      .npu_sched_sigmoid_fifo_read_en(sg_rd),
      .npu_sched_sigmoid_fifo_write_en(sg_wr),
      .npu_sched_output_fifo_write_en(out_wr),
      .npu_sched_pe_select_in(pe_sel),
      .npu_sched_pe_write_en(pe_we),
      .npu_sched_acc_fifo_read_en(acc_rd),
      .npu_sched_acc_fifo_write_en(acc_wr),
      .npu_sched_sigmoid_input_sel_pe(sg_in_sel),
      .npu_sched_sigmoid_input_en(sg_in_en),
      .npu_sched_sigmoid_function_sel(fn_sel),
      .npu_sched_active_cycles(active_cyc),
      .npu_sched_stall_cycles(stall_cyc)
   );

   assign obs_ctrl = {fn_sel, sg_in_en, sg_in_sel, acc_wr, acc_rd, pe_we, pe_sel,
                      out_wr, sg_wr, sg_rd, in_rd};

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset;
      npu_rst = 1'b1;
      tick;
      tick;
      npu_rst = 1'b0;
      prog.delete();
   endtask

   function automatic logic [WORD_W-1:0] mk(input logic last, input int rpt, input logic [CTRL_W-1:0] c);
      return {last, RPT_W'(rpt), c};
   endfunction

   task automatic wr(input logic [WORD_W-1:0] w);
      write_en = 1'b1;
      din      = w;
      tick;
      write_en = 1'b0;
      if (prog.size() < DEPTH) prog.push_back(w);
   endtask

   // Expand the program: each word repeated rpt+1 times, up to the first
   // word flagged last (or the end of the stored words), once per iteration.
   function automatic void build_exp(input int iter_in);
      int n_it;
      n_it = (iter_in == 0) ? 1 : iter_in;
      exp_q.delete();
      for (int it = 0; it < n_it; it++) begin
         for (int i = 0; i < prog.size(); i++) begin
            for (int r = 0; r <= int'(prog[i][CTRL_W +: RPT_W]); r++)
               exp_q.push_back(prog[i][CTRL_W-1:0]);
            if (prog[i][WORD_W-1]) break;
         end
      end
   endfunction

   task automatic run_prog(input string tag, input int iter_in, input int st_pos,
                           input int st_len, input bit wr_mid);
      build_exp(iter_in);
      for (int k = 0; k < st_len; k++) exp_q.insert(st_pos, '0);
      start = 1'b1;
      iter  = ITER_W'(iter_in);
      tick;
      start = 1'b0;
      chk({tag, "_lat_ctrl"}, 32'(obs_ctrl), 32'h0);
      chk({tag, "_lat_done"}, 32'(done), 32'h0);
      for (int p = 0; p < exp_q.size(); p++) begin
         stall = (p >= st_pos) && (p < st_pos + st_len);
         if (wr_mid && p == 1) begin
            write_en = 1'b1;
            din      = WORD_W'($urandom);
         end
         tick;
         stall    = 1'b0;
         write_en = 1'b0;
         chk({tag, "_ctrl"}, 32'(obs_ctrl), 32'(exp_q[p]));
         chk({tag, "_busy"}, 32'(busy), 32'h1);
         chk({tag, "_done_early"}, 32'(done), 32'h0);
      end
      tick;
      chk({tag, "_end_ctrl"}, 32'(obs_ctrl), 32'h0);
      chk({tag, "_end_busy"}, 32'(busy), 32'h0);
      chk({tag, "_done"}, 32'(done), 32'h1);
`ifdef NPU_SCHED_PERF_EN
      chk({tag, "_active"}, active_cyc, 32'(exp_q.size() - st_len));
      chk({tag, "_stallcnt"}, stall_cyc, 32'(st_len));
`else
      chk({tag, "_active"}, active_cyc, 32'h0);
      chk({tag, "_stallcnt"}, stall_cyc, 32'h0);
`endif
      tick;
      chk({tag, "_done_pulse"}, 32'(done), 32'h0);
   endtask

   initial begin
      int len, it_r, sp, sl;
      logic lst;

      tick;
      tick;
      npu_rst = 1'b0;
      chk("rst_ctrl", 32'(obs_ctrl), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_full", 32'(full), 32'h0);
      chk("rst_active", active_cyc, 32'h0);
      chk("rst_stall", stall_cyc, 32'h0);

      // Basic three-word program
      wr(mk(1'b0, 0, 16'h0001));
      wr(mk(1'b0, 2, 16'h0080));
      wr(mk(1'b1, 0, 16'h8008));
      run_prog("basic", 1, 0, 0, 1'b0);
      run_prog("iter3", 3, 0, 0, 1'b0);
      run_prog("iter0", 0, 0, 0, 1'b0);
      run_prog("stall", 1, 2, 2, 1'b0);
      run_prog("wr_run", 1, 0, 0, 1'b1);
      run_prog("after_wr", 2, 0, 0, 1'b0);

      // Abort in the second output cycle
      build_exp(1);
      start = 1'b1;
      iter  = 8'd1;
      tick;
      start = 1'b0;
      tick;
      chk("abort_w0", 32'(obs_ctrl), 32'(exp_q[0]));
      tick;
      chk("abort_w1", 32'(obs_ctrl), 32'(exp_q[1]));
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("abort_ctrl", 32'(obs_ctrl), 32'h0);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_done", 32'(done), 32'h0);
      tick;
      chk("abort_done2", 32'(done), 32'h0);
      run_prog("replay", 1, 0, 0, 1'b0);

      // Fill past capacity; no last flag, so playback ends at word DEPTH-1
      do_reset;
      for (int i = 0; i < DEPTH + 2; i++) begin
         wr(mk(1'b0, $urandom_range(0, 1), CTRL_W'($urandom)));
         if (i == DEPTH - 2) chk("full_early", 32'(full), 32'h0);
      end
      chk("full", 32'(full), 32'h1);
      run_prog("nolast", 1, 0, 0, 1'b0);

      // Empty program start, then reset in the middle of a run
      do_reset;
      run_prog("empty", 1, 0, 0, 1'b0);
      wr(mk(1'b1, 3, 16'h1234));
      start = 1'b1;
      iter  = 8'd2;
      tick;
      start = 1'b0;
      tick;
      tick;
      chk("midrst_pre", 32'(obs_ctrl), 32'h1234);
      npu_rst = 1'b1;
      tick;
      npu_rst = 1'b0;
      prog.delete();
      chk("midrst_ctrl", 32'(obs_ctrl), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_full", 32'(full), 32'h0);
      run_prog("midrst_empty", 1, 0, 0, 1'b0);

      // Randomized programs with random iteration counts and stalls
      for (int n = 0; n < 6; n++) begin
         do_reset;
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++) begin
            lst = (i == len - 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 4) == 0);
            wr(mk(lst, $urandom_range(0, 3), CTRL_W'($urandom)));
         end
         it_r = $urandom_range(0, 3);
         build_exp(it_r);
         if (exp_q.size() >= 2) begin
            sp = $urandom_range(1, exp_q.size() - 1);
            sl = $urandom_range(0, 3);
         end else begin
            sp = 0;
            sl = 0;
         end
         run_prog("rand", it_r, sp, sl, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
